// File: rtl/calc2_pkg.sv
`default_nettype none
// ============================================================================
// calc2_pkg : command/response encodings and capture-FSM state type for calc2
// Rev 1.0   : initial release
// ============================================================================
package calc2_pkg;

  localparam int CMD_W  = 4;
  localparam int RESP_W = 2;

  localparam logic [CMD_W-1:0] CMD_NONE = 4'd0;
  localparam logic [CMD_W-1:0] CMD_ADD  = 4'd1;
  localparam logic [CMD_W-1:0] CMD_SUB  = 4'd2;
  localparam logic [CMD_W-1:0] CMD_SHL  = 4'd5;
  localparam logic [CMD_W-1:0] CMD_SHR  = 4'd6;

  localparam logic [RESP_W-1:0] RESP_NONE = 2'd0;
  localparam logic [RESP_W-1:0] RESP_OK   = 2'd1;
  localparam logic [RESP_W-1:0] RESP_ERR  = 2'd2;

  typedef enum logic {
    CAP_IDLE = 1'b0,
    CAP_OP2  = 1'b1
  } cap_state_e;

endpackage
`default_nettype wire

// File: rtl/calc2_port_fifo.sv
`default_nettype none
// ============================================================================
// calc2_port_fifo : DEPTH-entry synchronous FIFO, extra pointer bit for full/empty
// Rev 1.0         : initial release
// ============================================================================
module calc2_port_fifo
  import calc2_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];
  // A push into a full queue is fine when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/calc2.sv
`default_nettype none
// ============================================================================
// calc2 : multi-port tagged calculator, per-port queues, round-robin shared ALU
// Rev 1.0 : initial release
// ============================================================================
module calc2
  import calc2_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 4,
  parameter int TAG_W     = 2
) (
  input  logic                          c_clk,
  input  logic                          reset,
  input  logic [NUM_PORTS*CMD_W-1:0]    req_cmd_in,
  input  logic [NUM_PORTS*TAG_W-1:0]    req_tag_in,
  input  logic [NUM_PORTS*DATA_W-1:0]   req_data_in,
  output logic [NUM_PORTS-1:0]          req_ready,
  output logic [NUM_PORTS*RESP_W-1:0]   out_resp,
  output logic [NUM_PORTS*DATA_W-1:0]   out_data,
  output logic [NUM_PORTS*TAG_W-1:0]    out_tag
);

  localparam int PW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int AW   = $clog2(DEPTH);
  localparam int SH_W = $clog2(DATA_W);

  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
  } entry_t;

  entry_t                      head [NUM_PORTS];
  entry_t                      h;
  logic [NUM_PORTS-1:0]        empty;
  logic [NUM_PORTS-1:0]        pop;
  logic                        grant_valid;
  logic [PW-1:0]               grant_idx;
  logic [PW-1:0]               rr_ptr_q, rr_ptr_d;
  logic [DATA_W:0]             sum;
  logic [SH_W-1:0]             shamt;
  logic [RESP_W-1:0]           alu_resp;
  logic [DATA_W-1:0]           alu_data;
  logic [NUM_PORTS*RESP_W-1:0] resp_q, resp_d;
  logic [NUM_PORTS*DATA_W-1:0] data_q, data_d;
  logic [NUM_PORTS*TAG_W-1:0]  tag_q, tag_d;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    cap_state_e        state_q, state_d;
    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [DATA_W-1:0] op1_q, op1_d;
    logic [CMD_W-1:0]  cmd_in;
    logic [DATA_W-1:0] data_in;
    logic [AW:0]       count;
    logic [AW+1:0]     used;
    entry_t            wentry;

    assign cmd_in  = req_cmd_in[p*CMD_W +: CMD_W];
    assign data_in = req_data_in[p*DATA_W +: DATA_W];
    // The entry still in OP2 already owns a slot, so it counts against DEPTH.
    assign used    = {1'b0, count} + {{(AW+1){1'b0}}, state_q == CAP_OP2};
    assign req_ready[p] = used < (AW+2)'(DEPTH);
    assign wentry  = {cmd_q, tag_q, op1_q, data_in};
    assign pop[p]  = grant_valid && (grant_idx == PW'(p));

    always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      tag_d   = tag_q;
      op1_d   = op1_q;
      if (state_q == CAP_IDLE) begin
        if (cmd_in != CMD_NONE && req_ready[p]) begin
          cmd_d   = cmd_in;
          tag_d   = req_tag_in[p*TAG_W +: TAG_W];
          op1_d   = data_in;
          state_d = CAP_OP2;
        end
      end else begin
        state_d = CAP_IDLE;
      end
    end

    always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
        state_q <= CAP_IDLE;
        cmd_q   <= '0;
        tag_q   <= '0;
        op1_q   <= '0;
      end else begin
        state_q <= state_d;
        cmd_q   <= cmd_d;
        tag_q   <= tag_d;
        op1_q   <= op1_d;
      end
    end

    calc2_port_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (c_clk),
      .rst_n (reset),
      .push  (state_q == CAP_OP2),
      .wdata (wentry),
      .pop   (pop[p]),
      .rdata (head[p]),
      .empty (empty[p]),
      .count (count)
    );
  end

  // Scan downward so the non-empty port closest after the pointer wins.
  always_comb begin
    int         idx;
    logic [PW-1:0] cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    cand        = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      cand = PW'(idx);
      if (!empty[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (grant_valid) begin
      rr_ptr_d = (grant_idx == PW'(NUM_PORTS - 1)) ? '0 : grant_idx + PW'(1);
    end
  end

  always_comb begin
    h        = head[grant_idx];
    sum      = {1'b0, h.op1} + {1'b0, h.op2};
    shamt    = h.op2[SH_W-1:0];
    alu_resp = RESP_ERR;
    alu_data = '0;
    case (h.cmd)
      CMD_ADD: if (!sum[DATA_W]) begin
        alu_resp = RESP_OK;
        alu_data = sum[DATA_W-1:0];
      end
      CMD_SUB: if (h.op2 <= h.op1) begin
        alu_resp = RESP_OK;
        alu_data = h.op1 - h.op2;
      end
      CMD_SHL: begin
        alu_resp = RESP_OK;
        alu_data = h.op1 << shamt;
      end
      CMD_SHR: begin
        alu_resp = RESP_OK;
        alu_data = h.op1 >> shamt;
      end
      default: ;
    endcase
  end

  always_comb begin
    resp_d = '0;
    data_d = '0;
    tag_d  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant_valid && grant_idx == PW'(p)) begin
        resp_d[p*RESP_W +: RESP_W] = alu_resp;
        data_d[p*DATA_W +: DATA_W] = alu_data;
        tag_d[p*TAG_W +: TAG_W]    = h.tag;
      end
    end
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= '0;
      resp_q   <= '0;
      data_q   <= '0;
      tag_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      resp_q   <= resp_d;
      data_q   <= data_d;
      tag_q    <= tag_d;
    end
  end

  assign out_resp = resp_q;
  assign out_data = data_q;
  assign out_tag  = tag_q;

endmodule
`default_nettype wire

// File: tb/tb_calc2.sv
`default_nettype none
// ============================================================================
// tb_calc2 : directed scoreboard bench for calc2 (4 ports, 32-bit, depth 4)
// Rev 1.0  : initial release
// ============================================================================
module tb_calc2;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int TW = 2;

  logic              c_clk = 1'b0;
  logic              reset = 1'b0;
  logic [NP*4-1:0]   req_cmd_in  = '0;
  logic [NP*TW-1:0]  req_tag_in  = '0;
  logic [NP*DW-1:0]  req_data_in = '0;
  logic [NP-1:0]     req_ready;
  logic [NP*2-1:0]   out_resp;
  logic [NP*DW-1:0]  out_data;
  logic [NP*TW-1:0]  out_tag;

  always #5 c_clk = ~c_clk;

  calc2 #(.NUM_PORTS(NP), .DATA_W(DW), .DEPTH(4), .TAG_W(TW)) dut (
    .c_clk       (c_clk),
    .reset       (reset),
    .req_cmd_in  (req_cmd_in),
    .req_tag_in  (req_tag_in),
    .req_data_in (req_data_in),
    .req_ready   (req_ready),
    .out_resp    (out_resp),
    .out_data    (out_data),
    .out_tag     (out_tag)
  );

  typedef struct {
    logic [1:0]    resp;
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    int            due;
  } exp_t;

  exp_t sb [NP][$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t model(input logic [3:0] cmd, input logic [TW-1:0] tag,
                                 input logic [DW-1:0] a, input logic [DW-1:0] b, input int due);
    exp_t e;
    logic [DW:0] s;
    e.resp = 2'd2;
    e.data = '0;
    e.tag  = tag;
    e.due  = due;
    case (cmd)
      4'd1: begin
        s = {1'b0, a} + {1'b0, b};
        if (s[DW] == 1'b0) begin e.resp = 2'd1; e.data = s[DW-1:0]; end
      end
      4'd2: if (!(b > a)) begin e.resp = 2'd1; e.data = a - b; end
      4'd5: begin e.resp = 2'd1; e.data = a << b[4:0]; end
      4'd6: begin e.resp = 2'd1; e.data = a >> b[4:0]; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic monitor();
    for (int p = 0; p < NP; p++) begin
      logic [1:0] r;
      exp_t       e;
      r = out_resp[p*2 +: 2];
      if (r == 2'd0) begin
        chk($sformatf("idle_data_p%0d", p), out_data[p*DW +: DW], 0);
        chk($sformatf("idle_tag_p%0d", p), out_tag[p*TW +: TW], 0);
      end else if (sb[p].size() == 0) begin
        chk($sformatf("unexpected_resp_p%0d", p), r, 0);
      end else begin
        e = sb[p].pop_front();
        chk($sformatf("resp_p%0d", p), r, e.resp);
        chk($sformatf("data_p%0d", p), out_data[p*DW +: DW], e.data);
        chk($sformatf("tag_p%0d", p), out_tag[p*TW +: TW], e.tag);
        if (e.due >= 0) chk($sformatf("latency_p%0d", p), cyc, e.due);
      end
    end
  endtask

  task automatic tick();
    @(posedge c_clk);
    cyc++;
    @(negedge c_clk);
    monitor();
  endtask

  task automatic set_cmd(input int p, input logic [3:0] cmd, input logic [TW-1:0] tag,
                         input logic [DW-1:0] d);
    req_cmd_in[p*4 +: 4]    = cmd;
    req_tag_in[p*TW +: TW]  = tag;
    req_data_in[p*DW +: DW] = d;
  endtask

  // Uncontended request: response must appear exactly three edges after issue.
  task automatic single(input int p, input logic [3:0] cmd, input logic [TW-1:0] tag,
                        input logic [DW-1:0] a, input logic [DW-1:0] b);
    set_cmd(p, cmd, tag, a);
    sb[p].push_back(model(cmd, tag, a, b, cyc + 3));
    tick();
    set_cmd(p, 4'd0, '0, b);
    tick();
  endtask

  initial begin
    logic [3:0]    ops [5];
    logic [3:0]    pc  [NP];
    logic [DW-1:0] pa  [NP];
    logic [DW-1:0] pb;
    logic [TW-1:0] tagc [NP];
    logic          acc [NP];
    int            drops;
    int            c0;

    ops = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd3};
    drops = 0;
    for (int p = 0; p < NP; p++) tagc[p] = TW'(p);

    #1;
    chk("reset_resp", out_resp, 0);
    chk("reset_data", out_data, 0);
    chk("reset_tag", out_tag, 0);
    chk("reset_ready", req_ready, 4'hF);
    @(negedge c_clk);
    @(negedge c_clk);
    reset = 1'b1;

    single(1, 4'd1, 2'd2, 32'h0000_0001, 32'h1FFF_FFFF);
    tick();
    tick();

    single(0, 4'd1, 2'd1, 32'hFFFF_FFFF, 32'h0000_0001);
    single(0, 4'd1, 2'd2, 32'hFFFF_FFFE, 32'h0000_0001);
    single(0, 4'd2, 2'd3, 32'h0000_0001, 32'h0000_000F);
    single(0, 4'd2, 2'd0, 32'h0000_000F, 32'h0000_0001);
    single(0, 4'd2, 2'd1, 32'h0000_0005, 32'h0000_0005);
    single(2, 4'd5, 2'd2, 32'h0000_0001, 32'd35);
    single(2, 4'd6, 2'd3, 32'h8000_0000, 32'd31);
    single(3, 4'd3, 2'd1, 32'h0000_0010, 32'h0000_0020);
    single(3, 4'd4, 2'd2, 32'h0000_0010, 32'h0000_0020);
    single(3, 4'd15, 2'd3, 32'h0000_0010, 32'h0000_0020);
    tick();
    tick();

    // Back-to-back streaming on all ports outruns the single ALU.
    for (int r = 0; r < 20; r++) begin
      for (int p = 0; p < NP; p++) begin
        acc[p] = req_ready[p];
        if (!acc[p]) drops++;
        pc[p] = ops[$urandom_range(0, 4)];
        pa[p] = $urandom;
        set_cmd(p, pc[p], tagc[p], pa[p]);
      end
      tick();
      for (int p = 0; p < NP; p++) begin
        pb = (r % 3 == 0) ? DW'($urandom_range(0, 40)) : $urandom;
        if (acc[p]) begin
          sb[p].push_back(model(pc[p], tagc[p], pa[p], pb, -1));
          tagc[p] = tagc[p] + 1'b1;
        end
        set_cmd(p, acc[p] ? 4'd1 : 4'd0, '0, pb);
      end
      tick();
    end
    for (int p = 0; p < NP; p++) set_cmd(p, 4'd0, '0, '0);
    repeat (30) tick();
    chk("ready_deasserted_seen", drops > 0, 1);
    for (int p = 0; p < NP; p++) chk($sformatf("stream_drained_p%0d", p), sb[p].size(), 0);

    // Reset between port 1's command and op2 while another response is out.
    set_cmd(0, 4'd1, 2'd1, 32'h11);
    set_cmd(2, 4'd1, 2'd2, 32'h22);
    @(posedge c_clk);
    @(negedge c_clk);
    set_cmd(0, 4'd0, '0, 32'h1);
    set_cmd(2, 4'd0, '0, 32'h2);
    @(posedge c_clk);
    @(negedge c_clk);
    set_cmd(0, 4'd0, '0, '0);
    set_cmd(2, 4'd0, '0, '0);
    set_cmd(1, 4'd1, 2'd3, 32'h33);
    @(posedge c_clk);
    #1;
    chk("pre_reset_resp_present", out_resp != 0, 1);
    #1 reset = 1'b0;
    #1;
    chk("midreset_resp", out_resp, 0);
    chk("midreset_data", out_data, 0);
    chk("midreset_tag", out_tag, 0);
    chk("midreset_ready", req_ready, 4'hF);
    set_cmd(1, 4'd0, '0, '0);
    @(negedge c_clk);
    reset = 1'b1;
    repeat (8) tick();

    // Fresh round-robin pointer: ports answer in order 0,1,2,3.
    c0 = cyc;
    for (int p = 0; p < NP; p++) begin
      pa[p] = DW'(100 * (p + 1));
      set_cmd(p, 4'd1, TW'(p + 1), pa[p]);
      sb[p].push_back(model(4'd1, TW'(p + 1), pa[p], DW'(p + 7), c0 + 3 + p));
    end
    tick();
    for (int p = 0; p < NP; p++) set_cmd(p, 4'd0, '0, DW'(p + 7));
    tick();
    repeat (6) tick();
    for (int p = 0; p < NP; p++) chk($sformatf("final_drained_p%0d", p), sb[p].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
